// File: rtl/bresenham_line_engine.sv
// -----------------------------------------------------------------------------
// bresenham_line_engine
//
// All-octant integer Bresenham line rasteriser. One line command is taken per
// cmd_valid/cmd_ready handshake. Every pixel of the line, both endpoints
// included, is then streamed over a back-pressured pixel interface. Each pixel
// carries a dash-pattern bit and a last flag. Only signed error-term
// arithmetic is used; there is no divider and no fractional gradient.
//
// Parameters
//   XW : x coordinate width
//   YW : y coordinate width
//   PW : dash pattern length
//
// Ports
//   clk          clock, rising edge
//   n_rst        synchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    engine idle and able to take a command
//   cmd_x0/y0    start point
//   cmd_x1/y1    end point
//   cmd_pattern  dash mask, bit i applies to pixels i, i+PW, ...
//   abort        cancel the line in progress (ignored while idle)
//   pix_valid    pixel fields valid
//   pix_ready    downstream accepts the pixel
//   pix_x/pix_y  pixel coordinate
//   pix_on       dash bit for this pixel
//   pix_last     pixel is the end point
//   busy         line setup or drawing in progress
//   done         one-cycle pulse after the end point is accepted
// -----------------------------------------------------------------------------
module bresenham_line_engine #(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x0,
    input  logic [YW-1:0] cmd_y0,
    input  logic [XW-1:0] cmd_x1,
    input  logic [YW-1:0] cmd_y1,
    input  logic [PW-1:0] cmd_pattern,
    input  logic          abort,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_on,
    output logic          pix_last,
    output logic          busy,
    output logic          done
);

    // Two guard bits above the widest coordinate keep 2*err in range:
    // err stays within [-dy, dx], so 2*err fits in a signed EW-bit word.
    localparam int EW = ((XW > YW) ? XW : YW) + 2;
    localparam int IW = (PW > 1) ? $clog2(PW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t state;

    // Latched command
    logic [XW-1:0] x0_r, x1_r;
    logic [YW-1:0] y0_r, y1_r;
    logic [PW-1:0] pattern_r;

    // Line stepping state; the current point lives in pix_x/pix_y
    logic signed [EW-1:0] dx, dy, err;
    logic                 sx_neg, sy_neg;
    logic [IW-1:0]        idx;

    // Zero-extend a coordinate into the signed error domain
    function automatic logic signed [EW-1:0] ext_x(input logic [XW-1:0] v);
        return $signed({{(EW-XW){1'b0}}, v});
    endfunction

    function automatic logic signed [EW-1:0] ext_y(input logic [YW-1:0] v);
        return $signed({{(EW-YW){1'b0}}, v});
    endfunction

    function automatic logic signed [EW-1:0] abs_ew(input logic signed [EW-1:0] v);
        return v[EW-1] ? -v : v;
    endfunction

    // Setup values derived from the latched endpoints
    logic signed [EW-1:0] setup_dx, setup_dy;

    always_comb begin
        setup_dx = abs_ew(ext_x(x1_r) - ext_x(x0_r));
        setup_dy = abs_ew(ext_y(y1_r) - ext_y(y0_r));
    end

    // Next pixel: both tests use the old error term, and both steps may
    // fire in the same cycle (diagonal move).
    logic signed [EW-1:0] e2, nxt_err;
    logic                 step_x, step_y;
    logic [XW-1:0]        nxt_x;
    logic [YW-1:0]        nxt_y;
    logic [IW-1:0]        nxt_idx;

    always_comb begin
        e2      = err <<< 1;
        step_x  = (e2 > -dy);
        step_y  = (e2 < dx);
        nxt_err = err;
        nxt_x   = pix_x;
        nxt_y   = pix_y;
        if (step_x) begin
            nxt_err = nxt_err - dy;
            nxt_x   = sx_neg ? (pix_x - XW'(1)) : (pix_x + XW'(1));
        end
        if (step_y) begin
            nxt_err = nxt_err + dx;
            nxt_y   = sy_neg ? (pix_y - YW'(1)) : (pix_y + YW'(1));
        end
        nxt_idx = (idx == IW'(PW-1)) ? '0 : (idx + IW'(1));
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_on    <= 1'b0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= '0;
            idx       <= '0;
            dx        <= '0;
            dy        <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
            x0_r      <= '0;
            y0_r      <= '0;
            x1_r      <= '0;
            y1_r      <= '0;
            pattern_r <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        x0_r      <= cmd_x0;
                        y0_r      <= cmd_y0;
                        x1_r      <= cmd_x1;
                        y1_r      <= cmd_y1;
                        pattern_r <= cmd_pattern;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        dx        <= setup_dx;
                        dy        <= setup_dy;
                        err       <= setup_dx - setup_dy;
                        sx_neg    <= (x1_r < x0_r);
                        sy_neg    <= (y1_r < y0_r);
                        idx       <= '0;
                        pix_x     <= x0_r;
                        pix_y     <= y0_r;
                        pix_on    <= pattern_r[0];
                        pix_last  <= (x0_r == x1_r) && (y0_r == y1_r);
                        pix_valid <= 1'b1;
                        state     <= DRAW;
                    end
                end

                DRAW: begin
                    // Abort beats a simultaneous final handshake: no done.
                    if (abort) begin
                        state     <= IDLE;
                        pix_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (pix_ready) begin
                        if (pix_last) begin
                            state     <= IDLE;
                            pix_valid <= 1'b0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            err      <= nxt_err;
                            idx      <= nxt_idx;
                            pix_x    <= nxt_x;
                            pix_y    <= nxt_y;
                            pix_on   <= pattern_r[nxt_idx];
                            pix_last <= (nxt_x == x1_r) && (nxt_y == y1_r);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    pix_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bresenham_line_engine.sv
module tb_bresenham_line_engine;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_x0, cmd_x1;
    logic [7:0] cmd_y0, cmd_y1;
    logic [7:0] cmd_pattern;
    logic       abort;
    logic       pix_valid;
    logic       pix_ready;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic       pix_on;
    logic       pix_last;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    int exp_x[$];
    int exp_y[$];
    int exp_on[$];

    bresenham_line_engine #(.XW(9), .YW(8), .PW(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_x1     (cmd_x1),
        .cmd_y1     (cmd_y1),
        .cmd_pattern(cmd_pattern),
        .abort      (abort),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_on     (pix_on),
        .pix_last   (pix_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [7:0] pat);
        int g = 0;
        while (cmd_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_x0      = 9'(x0);
        cmd_y0      = 8'(y0);
        cmd_x1      = 9'(x1);
        cmd_y1      = 8'(y1);
        cmd_pattern = pat;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_cmd_ready", cmd_ready, 0);
        check("accept_no_pix_yet", pix_valid, 0);
    endtask

    // Streams a line with pix_ready high (optionally stalling 3 cycles on one
    // pixel), checks the queued leading pixels, the count, the end point and
    // the done/cmd_ready behaviour after the final handshake.
    task automatic drain_line(input string tag, input int n_exp, input int end_x,
                              input int end_y, input int stall_at);
        int got = 0;
        int guard = 0;
        int last_idx = -1;
        int last_x = -1;
        int last_y = -1;
        pix_ready = 1'b1;
        while (got < n_exp && guard < 2000) begin
            if (pix_valid === 1'b1) begin
                if (got == stall_at) begin
                    pix_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        check({tag, "_stall_valid"}, pix_valid, 1);
                        check({tag, "_stall_x"}, pix_x, exp_x[got]);
                        check({tag, "_stall_y"}, pix_y, exp_y[got]);
                        check({tag, "_stall_on"}, pix_on, exp_on[got]);
                        check({tag, "_stall_last"}, pix_last, 0);
                    end
                    pix_ready = 1'b1;
                end
                if (got < exp_x.size()) begin
                    check({tag, "_x"}, pix_x, exp_x[got]);
                    check({tag, "_y"}, pix_y, exp_y[got]);
                    check({tag, "_on"}, pix_on, exp_on[got]);
                    check({tag, "_last"}, pix_last, (got == n_exp - 1) ? 1 : 0);
                end
                if (pix_last === 1'b1 && last_idx < 0) begin
                    last_idx = got;
                    last_x   = int'(pix_x);
                    last_y   = int'(pix_y);
                end
                got++;
            end
            @(negedge clk);
            guard++;
        end
        check({tag, "_count"}, got, n_exp);
        check({tag, "_last_index"}, last_idx, n_exp - 1);
        check({tag, "_end_x"}, last_x, end_x);
        check({tag, "_end_y"}, last_y, end_y);
        check({tag, "_done"}, done, 1);
        check({tag, "_done_cmd_ready"}, cmd_ready, 1);
        check({tag, "_done_pix_valid"}, pix_valid, 0);
        check({tag, "_done_busy"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    task automatic wait_pix(input string tag);
        int g = 0;
        while (pix_valid !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_first_pix"}, pix_valid, 1);
    endtask

    initial begin
        n_rst       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_x0      = '0;
        cmd_y0      = '0;
        cmd_x1      = '0;
        cmd_y1      = '0;
        cmd_pattern = '0;
        abort       = 1'b0;
        pix_ready   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_pix_on", pix_on, 0);
        check("rst_pix_last", pix_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_release_cmd_ready", cmd_ready, 1);

        // Horizontal line
        exp_x = '{0, 1, 2, 3, 4};
        exp_y = '{0, 0, 0, 0, 0};
        exp_on = '{1, 1, 1, 1, 1};
        send_cmd(0, 0, 4, 0, 8'hFF);
        drain_line("horiz", 5, 4, 0, -1);

        // Steep, both coordinates decreasing
        exp_x = '{2, 2, 1, 1, 0, 0};
        exp_y = '{5, 4, 3, 2, 1, 0};
        exp_on = '{1, 1, 1, 1, 1, 1};
        send_cmd(2, 5, 0, 0, 8'hFF);
        drain_line("steep_neg", 6, 0, 0, -1);

        // Single point
        exp_x = '{7};
        exp_y = '{7};
        exp_on = '{1};
        send_cmd(7, 7, 7, 7, 8'hFF);
        drain_line("point", 1, 7, 7, -1);

        // Dash pattern with a 3-cycle stall on the 4th pixel
        exp_x = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        exp_y = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
        exp_on = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        send_cmd(0, 0, 9, 3, 8'b0000_0101);
        drain_line("dash", 10, 9, 3, 3);

        // Full span, leading pixels hand-stepped from err=256
        exp_x = '{511, 510, 509};
        exp_y = '{255, 255, 254};
        exp_on = '{1, 1, 1};
        send_cmd(511, 255, 0, 0, 8'hFF);
        drain_line("span", 512, 0, 0, -1);

        // Abort on the 3rd pixel
        send_cmd(0, 0, 20, 0, 8'hFF);
        pix_ready = 1'b1;
        wait_pix("abort");
        @(negedge clk);
        @(negedge clk);
        check("abort_third_pix_x", pix_x, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_pix_valid", pix_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_done_later", done, 0);

        // Reset mid-line
        send_cmd(0, 0, 20, 0, 8'hFF);
        wait_pix("midrst");
        @(negedge clk);
        @(negedge clk);
        check("midrst_third_pix_x", pix_x, 2);
        n_rst = 1'b0;
        @(negedge clk);
        check("midrst_pix_valid", pix_valid, 0);
        check("midrst_pix_x", pix_x, 0);
        check("midrst_pix_y", pix_y, 0);
        check("midrst_pix_on", pix_on, 0);
        check("midrst_pix_last", pix_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        n_rst = 1'b1;
        @(negedge clk);
        check("midrst_release_cmd_ready", cmd_ready, 1);
        check("midrst_release_done", done, 0);
        @(negedge clk);
        check("midrst_no_done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bresenham_line_engine.md
Name: bresenham_line_engine

Overview:
Parametrised, all-octant integer Bresenham line rasteriser. It accepts one line command per valid/ready handshake and streams every pixel of the line, endpoints inclusive, over a back-pressured pixel interface. Each pixel carries a dash-pattern bit and a last flag. It sits between the draw-command decoder and the frame-buffer write arbiter. There is no division and no fixed-point gradient; all arithmetic is signed integer error-term arithmetic.

Parameters:
XW, 9, x coordinate width in bits (screen width up to 2^XW)
YW, 8, y coordinate width in bits
PW, 8, dash-pattern length in bits

Ports:
clk  in  1  clock, all logic on rising edge
n_rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command (IDLE only)
cmd_x0  in  XW  start x
cmd_y0  in  YW  start y
cmd_x1  in  XW  end x
cmd_y1  in  YW  end y
cmd_pattern  in  PW  dash mask; bit i applies to pixels i, i+PW, ...
abort  in  1  cancel the current line
pix_valid  out  1  pix_* fields valid
pix_ready  in  1  downstream accepts pixel
pix_x  out  XW  pixel x
pix_y  out  YW  pixel y
pix_on  out  1  pattern bit for this pixel (1 = draw)
pix_last  out  1  this pixel is the end point
busy  out  1  high in SETUP or DRAW
done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is synchronous and active-low. While n_rst=0 on a rising edge, the engine enters state IDLE and sets cmd_ready=0, pix_valid=0, pix_x=0, pix_y=0, pix_on=0, pix_last=0, busy=0, done=0, error and pattern index=0. cmd_ready rises to 1 in the first cycle after reset is released.
- Reset during an operation discards the line; no done pulse is produced.
- States: IDLE, SETUP, DRAW.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register the endpoints and pattern, then go to SETUP.
- SETUP (one cycle):
  - dx=|x1-x0|, dy=|y1-y0|.
  - sx=+1 if x1>=x0, else -1; sy=+1 if y1>=y0, else -1.
  - err=dx-dy.
  - cur=(x0,y0), pattern index=0. Go to DRAW.
- Error width: EW=max(XW,YW)+2 bits, signed, so 2*err never overflows.
- Latency: command accepted at edge T; first pix_valid=1 in the cycle after edge T+1.
- DRAW: pix_valid=1, pix_x/pix_y=cur, pix_on=pattern[idx], pix_last=(cur==(x1,y1)).
- On pix_valid&&pix_ready with pix_last=0, using the old err in both tests:
  - e2=2*err.
  - If e2>-dy: err-=dy and x+=sx.
  - If e2<dx: err+=dx and y+=sy.
  - Both updates may occur in the same cycle.
  - idx=(idx+1) mod PW.
- On pix_valid&&pix_ready with pix_last=1: go to IDLE, done=1 for exactly one cycle, cmd_ready=1 in that same cycle.
- Pixel count is always max(dx,dy)+1. Coordinates never leave the bounding box of the endpoints, so there is no wrap-around.
- Backpressure: while pix_valid=1 and pix_ready=0, all pix_* outputs and internal state hold. pix_valid never drops in DRAW without a handshake.
- Degenerate line (x0==x1 and y0==y1): exactly one pixel, with pix_last=1.
- Pure horizontal or vertical lines and 45-degree lines need no special case; they follow directly from the error rules.
- abort=1 in SETUP or DRAW: next state is IDLE with pix_valid=0 and no done pulse. abort in IDLE is ignored.
- If abort and a final handshake occur in the same cycle, abort wins: the pixel counts as accepted, but no done pulse is produced.
- busy=1 exactly when the state is SETUP or DRAW.
- A new command can be accepted no earlier than the cycle in which done is asserted.

Test Plan:
- Horizontal line: (0,0)->(4,0), pattern 8'hFF, pix_ready=1 → five pixels x=0..4, y=0, pix_on=1, pix_last only on (4,0), done pulses the cycle after, cmd_ready=1 in that cycle.
- Steep, both coordinates decreasing: (2,5)->(0,0) → pixels (2,5),(2,4),(1,3),(1,2),(0,1),(0,0), last flagged on (0,0).
- Single point: (7,7)->(7,7) → exactly one pixel (7,7) with pix_last=1, then done.
- Dash pattern plus backpressure: (0,0)->(9,3), pattern 8'b0000_0101, pix_ready deasserted for 3 cycles on the 4th pixel → pix_on sequence 1,0,1,0,0,0,0,0,1,0; outputs stable during the stall; ten pixels total.
- Full span: (511,255)->(0,0) with XW=9, YW=8 → 512 pixels, first (511,255), last (0,0); no overflow of the error term.
- Abort and reset: abort asserted on the 3rd pixel of (0,0)->(20,0) → IDLE next cycle, no done. Repeat the same line with n_rst=0 mid-line → all outputs 0, no done, and cmd_ready=1 one cycle after release.
